// File: rtl/count_sequencer.sv
// Event-counter sequencer: IDLE/RUN/HOLD/DONE with prescaler, up/down stepping and snapshot handshake.
// Optional periodic mode under `COUNT_SEQ_AUTORELOAD_EN.
module count_sequencer #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      term_val,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  up_dn,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done,
    input  logic                  snap_req,
    output logic                  snap_ack,
    output logic [WIDTH-1:0]      snap_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WIDTH-1:0]      CNT_ONE = 1;
    localparam logic [PRESCALE_W-1:0] PS_ONE  = 1;

    logic [1:0]            state;
    logic [PRESCALE_W-1:0] prescaler;
    logic [PRESCALE_W-1:0] cfg_prescale;
    logic [WIDTH-1:0]      cfg_term;
    logic                  cfg_up;
    logic [WIDTH-1:0]      stepped;
    logic                  tick;
    logic                  can_term;
    logic                  terminal;

`ifdef COUNT_SEQ_AUTORELOAD_EN
    logic [WIDTH-1:0] cfg_load;
    // After a terminal step the count shows term_val; the following step reloads.
    logic             reload_pend;
    assign terminal = tick && !reload_pend && (stepped == cfg_term);
`else
    assign terminal = tick && (stepped == cfg_term);
`endif

    assign stepped  = cfg_up ? (count + CNT_ONE) : (count - CNT_ONE);
    assign tick     = (prescaler == cfg_prescale);
    // A terminal step beats a pause raised in RUN; HOLD stays frozen while pause is high.
    assign can_term = (state == S_RUN) || ((state == S_HOLD) && !pause);
    assign busy     = (state == S_RUN) || (state == S_HOLD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            count        <= '0;
            done         <= 1'b0;
            prescaler    <= '0;
            cfg_prescale <= '0;
            cfg_term     <= '0;
            cfg_up       <= 1'b0;
`ifdef COUNT_SEQ_AUTORELOAD_EN
            cfg_load     <= '0;
            reload_pend  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (stop) begin
                state <= S_IDLE;
`ifdef COUNT_SEQ_AUTORELOAD_EN
                reload_pend <= 1'b0;
`endif
            end else if (start) begin
                state        <= S_RUN;
                count        <= load_val;
                prescaler    <= '0;
                cfg_prescale <= prescale;
                cfg_term     <= term_val;
                cfg_up       <= up_dn;
`ifdef COUNT_SEQ_AUTORELOAD_EN
                cfg_load     <= load_val;
                reload_pend  <= 1'b0;
`endif
            end else if (busy) begin
                if (can_term && terminal) begin
                    count     <= cfg_term;
                    done      <= 1'b1;
                    prescaler <= '0;
`ifdef COUNT_SEQ_AUTORELOAD_EN
                    state       <= S_RUN;
                    reload_pend <= 1'b1;
`else
                    state     <= S_DONE;
`endif
                end else if (pause) begin
                    state <= S_HOLD;
                end else begin
                    state <= S_RUN;
                    if (tick) begin
                        prescaler <= '0;
`ifdef COUNT_SEQ_AUTORELOAD_EN
                        count       <= reload_pend ? cfg_load : stepped;
                        reload_pend <= 1'b0;
`else
                        count     <= stepped;
`endif
                    end else begin
                        prescaler <= prescaler + PS_ONE;
                    end
                end
            end
        end
    end

    // Snapshot handshake runs regardless of FSM state; captures the pre-step count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_ack  <= 1'b0;
            snap_data <= '0;
        end else if (snap_req && !snap_ack) begin
            snap_ack  <= 1'b1;
            snap_data <= count;
        end else if (!snap_req && snap_ack) begin
            snap_ack  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: vector table, corner sequences, randomized run vs. reference model.
// Define COUNT_SEQ_AUTORELOAD_EN to exercise the periodic-mode build instead.
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, stop = 1'b0, pause = 1'b0, up_dn = 1'b0, snap_req = 1'b0;
    logic [3:0] load_val = '0, term_val = '0;
    logic [7:0] prescale = '0;
    logic [3:0] count, snap_data;
    logic       busy, done, snap_ack;

    int total = 0;
    int bad   = 0;

    count_sequencer #(.WIDTH(4), .PRESCALE_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .load_val(load_val), .term_val(term_val), .prescale(prescale), .up_dn(up_dn),
        .count(count), .busy(busy), .done(done),
        .snap_req(snap_req), .snap_ack(snap_ack), .snap_data(snap_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit st, sp, pa;
        int ld, tv, ps;
        bit up;
        int c;
        bit b, d;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit st, input bit sp, input bit pa, input int ld, input int tv,
                          input int ps, input bit up);
        start = st; stop = sp; pause = pa;
        load_val = 4'(ld); term_val = 4'(tv); prescale = 8'(ps); up_dn = up;
    endtask

    task automatic addv(input bit st, input bit sp, input bit pa, input int ld, input int tv,
                        input int ps, input bit up, input int c, input bit b, input bit d);
        vec_t v;
        v.st = st; v.sp = sp; v.pa = pa; v.ld = ld; v.tv = tv; v.ps = ps; v.up = up;
        v.c = c; v.b = b; v.d = d;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0);
        snap_req = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Reference model: phase 0 idle, 1 run, 2 hold, 3 done; m_left = edges until next step.
    int m_phase, m_count, m_term, m_pre, m_left, m_sdata;
    bit m_up, m_done, m_ack;

    task automatic model_reset();
        m_phase = 0; m_count = 0; m_term = 0; m_pre = 0; m_left = 1; m_up = 0;
        m_done = 0; m_ack = 0; m_sdata = 0;
    endtask

    task automatic model_step();
        int prev;
        int nxt;
        prev = m_count;
        m_done = 0;
        if (stop) begin
            m_phase = 0;
        end else if (start) begin
            m_count = load_val; m_term = term_val; m_pre = prescale; m_up = up_dn;
            m_left = prescale + 1; m_phase = 1;
        end else if (m_phase == 1 || m_phase == 2) begin
            nxt = m_up ? (m_count + 1) % 16 : (m_count + 15) % 16;
            if (m_left == 1 && nxt == m_term && (m_phase == 1 || !pause)) begin
                m_count = m_term; m_phase = 3; m_done = 1;
            end else if (pause) begin
                m_phase = 2;
            end else begin
                m_phase = 1;
                if (m_left == 1) begin
                    m_count = nxt;
                    m_left = m_pre + 1;
                end else begin
                    m_left--;
                end
            end
        end
        if (snap_req && !m_ack) begin
            m_ack = 1; m_sdata = prev;
        end else if (!snap_req && m_ack) begin
            m_ack = 0;
        end
    endtask

    initial begin
        // reset state
        tick();
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ack", snap_ack, 0);
        chk("rst_sdata", snap_data, 0);
        reset = 1'b0;

`ifdef COUNT_SEQ_AUTORELOAD_EN
        begin
            int exp_seq[6] = '{3, 4, 2, 3, 4, 2};
            set_in(1, 0, 0, 2, 4, 0, 1);
            tick();
            chk("ar_load", count, 2);
            set_in(0, 0, 0, 0, 0, 0, 0);
            for (int i = 0; i < 6; i++) begin
                tick();
                chk("ar_count", count, exp_seq[i]);
                chk("ar_done", done, exp_seq[i] == 4);
                chk("ar_busy", busy, 1);
            end
        end
`else
        // up to terminal
        addv(1,0,0, 3,7,0,1,  3,1,0);
        addv(0,0,0, 0,0,0,0,  4,1,0);
        addv(0,0,0, 0,0,0,0,  5,1,0);
        addv(0,0,0, 0,0,0,0,  6,1,0);
        addv(0,0,0, 0,0,0,0,  7,0,1);
        addv(0,0,0, 0,0,0,0,  7,0,0);
        // restart from DONE: down count with wrap, prescale 2
        addv(1,0,0, 1,14,2,0, 1,1,0);
        addv(0,0,0, 0,0,0,0,  1,1,0);
        addv(0,0,0, 0,0,0,0,  1,1,0);
        addv(0,0,0, 0,0,0,0,  0,1,0);
        addv(0,0,0, 0,0,0,0,  0,1,0);
        addv(0,0,0, 0,0,0,0,  0,1,0);
        addv(0,0,0, 0,0,0,0, 15,1,0);
        addv(0,0,0, 0,0,0,0, 15,1,0);
        addv(0,0,0, 0,0,0,0, 15,1,0);
        addv(0,0,0, 0,0,0,0, 14,0,1);
        addv(0,0,0, 0,0,0,0, 14,0,0);
        // pause with prescaler frozen at 1, then stop mid-run
        addv(1,0,0, 0,15,1,1, 0,1,0);
        addv(0,0,0, 0,0,0,0,  0,1,0);
        addv(0,0,1, 0,0,0,0,  0,1,0);
        addv(0,0,1, 0,0,0,0,  0,1,0);
        addv(0,0,1, 0,0,0,0,  0,1,0);
        addv(0,0,0, 0,0,0,0,  1,1,0);
        addv(0,0,0, 0,0,0,0,  1,1,0);
        addv(0,0,0, 0,0,0,0,  2,1,0);
        addv(0,1,0, 0,0,0,0,  2,0,0);
        addv(0,0,0, 0,0,0,0,  2,0,0);
        foreach (tbl[i]) begin
            set_in(tbl[i].st, tbl[i].sp, tbl[i].pa, tbl[i].ld, tbl[i].tv, tbl[i].ps, tbl[i].up);
            tick();
            chk($sformatf("vec%0d_count", i), count, tbl[i].c);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].b);
            chk($sformatf("vec%0d_done", i), done, tbl[i].d);
        end

        // stop on the terminal-step cycle
        set_in(1, 0, 0, 5, 7, 0, 1); tick();
        set_in(0, 0, 0, 0, 0, 0, 0); tick();
        chk("stopterm_pre", count, 6);
        stop = 1'b1; tick();
        chk("stopterm_count", count, 6);
        chk("stopterm_busy", busy, 0);
        chk("stopterm_done", done, 0);
        stop = 1'b0; tick();
        chk("stopterm_done2", done, 0);

        // pause on the terminal-step cycle: DONE wins
        set_in(1, 0, 0, 5, 6, 0, 1); tick();
        set_in(0, 0, 1, 0, 0, 0, 0); tick();
        chk("pauseterm_count", count, 6);
        chk("pauseterm_done", done, 1);
        chk("pauseterm_busy", busy, 0);
        tick();
        chk("pauseterm_done2", done, 0);
        pause = 1'b0;

        // load_val == term_val runs a full 16 steps
        set_in(1, 0, 0, 9, 9, 0, 1); tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        begin
            int n = 0;
            bit seen = 0;
            while (n < 40 && !seen) begin
                tick();
                n++;
                seen = done;
            end
            if (!seen) chk("wrap_timeout", 0, 1);
            else begin
                chk("wrap_steps", n, 16);
                chk("wrap_count", count, 9);
            end
        end

        // snapshot during counting
        do_reset();
        set_in(1, 0, 0, 3, 12, 0, 1); tick();
        set_in(0, 0, 0, 0, 0, 0, 0); tick(); tick();
        chk("snap_pre", count, 5);
        snap_req = 1'b1; tick();
        chk("snap_ack1", snap_ack, 1);
        chk("snap_data1", snap_data, 5);
        chk("snap_count1", count, 6);
        tick(); tick();
        chk("snap_data3", snap_data, 5);
        chk("snap_count3", count, 8);
        chk("snap_ack3", snap_ack, 1);
        snap_req = 1'b0; tick();
        chk("snap_ackclr", snap_ack, 0);

        // reset asserted mid-RUN with a handshake in flight
        do_reset();
        set_in(1, 0, 0, 2, 15, 0, 1); snap_req = 1'b1; tick();
        start = 1'b0; tick(); tick();
        chk("midrst_pre_ack", snap_ack, 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ack", snap_ack, 0);
        chk("midrst_sdata", snap_data, 0);
        snap_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("midrst_idle_busy", busy, 0);
        chk("midrst_idle_count", count, 0);

        // randomized run against the reference model
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(15) == 0);
            stop = ($urandom_range(39) == 0);
            if ($urandom_range(5) == 0) pause = ~pause;
            load_val = 4'($urandom_range(15));
            term_val = 4'($urandom_range(15));
            prescale = 8'($urandom_range(3));
            up_dn = 1'($urandom_range(1));
            if ($urandom_range(3) == 0) snap_req = ~snap_req;
            model_step();
            tick();
            chk("rnd_count", count, m_count);
            chk("rnd_busy", busy, (m_phase == 1 || m_phase == 2));
            chk("rnd_done", done, m_done);
            chk("rnd_ack", snap_ack, m_ack);
            chk("rnd_sdata", snap_data, m_sdata);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
